// File: rtl/fifo_param.sv
// fifo_param: single-clock elastic buffer between datapath producer and consumer.
// Parametrised width/depth, registered status flags that track the post-edge
// occupancy, sticky overflow/underflow, synchronous flush and a read-valid strobe.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  rd_valid,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fifo_counter,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

  // Storage (not reset: contents survive reset and flush)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] buf_out_q, buf_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ae_q, ae_d;
  logic                  af_q, af_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;

  // Accept decisions from pre-edge flags; a full FIFO still takes a push when a pop frees a slot
  always_comb begin
    wr_acc = wr_en & (~full_q | rd_en);
    rd_acc = rd_en & ~empty_q;
    // Reset held low must not leak a write into storage
    mem_we = wr_acc & ~clear & rst;
  end

  // Pointer advance; flush returns both pointers to the origin
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Occupancy: simultaneous accepted push and pop leave it unchanged
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Read port: data register only moves on an accepted pop, strobe follows the pop
  always_comb begin
    buf_out_d  = buf_out_q;
    rd_valid_d = 1'b0;
    if (!clear) begin
      rd_valid_d = rd_acc;
      if (rd_acc) buf_out_d = mem_q[rd_ptr_q];
    end
  end

  // Sticky error flags: any rejected request latches until flush or reset
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clear) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr_en && !wr_acc) ovf_d = 1'b1;
      if (rd_en && !rd_acc) udf_d = 1'b1;
    end
  end

  // Status flags derived from the next occupancy so they agree with it after the edge
  always_comb begin
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= buf_in;
  end

  // Control and status state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      buf_out_q  <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ae_q       <= 1'b1;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      buf_out_q  <= buf_out_d;
      rd_valid_q <= rd_valid_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ae_q       <= ae_d;
      af_q       <= af_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign buf_out      = buf_out_q;
  assign rd_valid     = rd_valid_q;
  assign buf_empty    = empty_q;
  assign buf_full     = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign fifo_counter = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] buf_in = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] buf_out;
  logic       rd_valid, buf_empty, buf_full, almost_empty, almost_full;
  logic [3:0] fifo_counter;
  logic       overflow, underflow;

  int compared = 0;
  int mismatched = 0;

  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .buf_in(buf_in),
    .rd_en(rd_en), .buf_out(buf_out), .rd_valid(rd_valid), .buf_empty(buf_empty),
    .buf_full(buf_full), .almost_empty(almost_empty), .almost_full(almost_full),
    .fifo_counter(fifo_counter), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, behaviour straight from the accept rules
  logic [7:0] mq[$];
  logic [7:0] m_out = 8'h00;
  logic       m_rv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  bit         m_wa, m_ra;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_out = 8'h00; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (clear) begin
      mq.delete();
      m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      m_wa = wr_en && (mq.size() < 8 || rd_en);
      m_ra = rd_en && (mq.size() != 0);
      if (m_ra) m_out = mq.pop_front();
      if (m_wa) mq.push_back(buf_in);
      m_rv = m_ra;
      if (wr_en && !m_wa) m_ovf = 1'b1;
      if (rd_en && !m_ra) m_udf = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("m_count",   32'(fifo_counter), 32'(sz));
    chk("m_empty",   32'(buf_empty),    32'(sz == 0));
    chk("m_full",    32'(buf_full),     32'(sz == 8));
    chk("m_aempty",  32'(almost_empty), 32'(sz <= 2));
    chk("m_afull",   32'(almost_full),  32'(sz >= 6));
    chk("m_buf_out", 32'(buf_out),      32'(m_out));
    chk("m_rvalid",  32'(rd_valid),     32'(m_rv));
    chk("m_ovf",     32'(overflow),     32'(m_ovf));
    chk("m_udf",     32'(underflow),    32'(m_udf));
  end

  // One clock of stimulus; returns 1 time unit after the edge
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; buf_in = d; rd_en = r; clear = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic push(input logic [7:0] d); step(1'b1, d, 1'b0, 1'b0); endtask

  task automatic pop_exp(input logic [7:0] e, input string nm);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk({nm, "_data"}, 32'(buf_out), 32'(e));
    chk({nm, "_rv"},   32'(rd_valid), 32'd1);
  endtask

  initial begin
    // 1. Reset and basic order
    #1 rst = 1'b0;
    #2;
    chk("rst_count", 32'(fifo_counter), 32'd0);
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_ae",    32'(almost_empty), 32'd1);
    chk("rst_full",  32'(buf_full), 32'd0);
    chk("rst_af",    32'(almost_full), 32'd0);
    chk("rst_out",   32'(buf_out), 32'd0);
    chk("rst_flags", {29'd0, rd_valid, overflow, underflow}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    push(8'd1); push(8'd2); push(8'd3);
    chk("s1_count3", 32'(fifo_counter), 32'd3);
    pop_exp(8'd1, "s1_pop1");
    pop_exp(8'd2, "s1_pop2");
    pop_exp(8'd3, "s1_pop3");
    chk("s1_count0", 32'(fifo_counter), 32'd0);
    chk("s1_empty",  32'(buf_empty), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("s1_rv_drop", 32'(rd_valid), 32'd0);
    chk("s1_hold",    32'(buf_out), 32'd3);

    // 2. Fill, flags and overflow
    for (int i = 1; i <= 9; i++) begin
      push(8'(i * 10));
      if (i == 5) chk("s2_af_at5", 32'(almost_full), 32'd0);
      if (i == 6) chk("s2_af_at6", 32'(almost_full), 32'd1);
      if (i == 7) chk("s2_full_at7", 32'(buf_full), 32'd0);
      if (i == 8) chk("s2_full_at8", 32'(buf_full), 32'd1);
    end
    chk("s2_ovf",   32'(overflow), 32'd1);
    chk("s2_count", 32'(fifo_counter), 32'd8);
    for (int i = 1; i <= 8; i++) pop_exp(8'(i * 10), "s2_pop");
    chk("s2_empty", 32'(buf_empty), 32'd1);

    // 3. Simultaneous push and pop while full
    for (int i = 1; i <= 8; i++) push(8'(i * 10));
    step(1'b1, 8'd100, 1'b1, 1'b0);
    chk("s3_out",   32'(buf_out), 32'd10);
    chk("s3_count", 32'(fifo_counter), 32'd8);
    chk("s3_full",  32'(buf_full), 32'd1);
    for (int i = 2; i <= 8; i++) pop_exp(8'(i * 10), "s3_pop");
    pop_exp(8'd100, "s3_pop_last");
    chk("s3_empty", 32'(buf_empty), 32'd1);

    // 4. Simultaneous push and pop while empty
    step(1'b1, 8'd5, 1'b1, 1'b0);
    chk("s4_count", 32'(fifo_counter), 32'd1);
    chk("s4_udf",   32'(underflow), 32'd1);
    chk("s4_rv",    32'(rd_valid), 32'd0);
    pop_exp(8'd5, "s4_pop");

    // 5. Wrap-around with error flags cleared first
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      push(8'(k * 7 + 3));
      chk("s5_count1", 32'(fifo_counter), 32'd1);
      pop_exp(8'(k * 7 + 3), "s5_pop");
      chk("s5_count0", 32'(fifo_counter), 32'd0);
    end
    chk("s5_errs", {30'd0, overflow, underflow}, 32'd0);

    // 6. Clear with a colliding write, then asynchronous reset
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) push(8'(8'h41 + i));
    for (int i = 0; i < 3; i++) pop_exp(8'(8'h41 + i), "s6_pop");
    chk("s6_count5", 32'(fifo_counter), 32'd5);
    chk("s6_errs",   {30'd0, overflow, underflow}, 32'd3);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("s6_clr_count", 32'(fifo_counter), 32'd0);
    chk("s6_clr_empty", 32'(buf_empty), 32'd1);
    chk("s6_clr_errs",  {30'd0, overflow, underflow}, 32'd0);
    chk("s6_clr_out",   32'(buf_out), 32'h43);
    push(8'd7);
    chk("s6_push7", 32'(fifo_counter), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("s6_arst_count", 32'(fifo_counter), 32'd0);
    chk("s6_arst_out",   32'(buf_out), 32'd0);
    chk("s6_arst_empty", 32'(buf_empty), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s6_post_udf", 32'(underflow), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the team's 8-bit, 8-entry `fifo`. It adds configurable data width and depth, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It also adds a synchronous flush and a read-valid strobe, and it accepts simultaneous push and pop when full. It sits between the producer and consumer stages of the datapath as a single-clock elastic buffer.

## Interface
- `DATA_WIDTH`, default 8: word width in bits.
- `ADDR_WIDTH`, default 3: pointer width; depth is `DEPTH = 2**ADDR_WIDTH`.
- `AF_THRESH`, default 6: `almost_full` asserts when count >= AF_THRESH. Legal range 1..DEPTH.
- `AE_THRESH`, default 2: `almost_empty` asserts when count <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush, active-high.
- `wr_en`  in  1  push request.
- `buf_in`  in  DATA_WIDTH  push data.
- `rd_en`  in  1  pop request.
- `buf_out`  out  DATA_WIDTH  registered pop data.
- `rd_valid`  out  1  high for one cycle after an accepted pop.
- `buf_empty`  out  1  count == 0.
- `buf_full`  out  1  count == DEPTH.
- `almost_empty`  out  1  count <= AE_THRESH.
- `almost_full`  out  1  count >= AF_THRESH.
- `fifo_counter`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.

## Operation
**Storage and pointers**
- Storage is DEPTH x DATA_WIDTH registers.
- `wr_ptr` and `rd_ptr` are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Occupancy is held in a separate ADDR_WIDTH+1-bit counter.

**Accept rules** (evaluated on pre-edge state)
- `wr_acc` = wr_en & (!full | rd_en).
- `rd_acc` = rd_en & !empty.
- Empty with both requests: the write is accepted and the read is rejected. `underflow` sets.
- Full with both requests: both are accepted. Count is unchanged and pointers advance.

**Counter update**
- +1 on write only, -1 on read only, unchanged on both or neither.
- It never exceeds DEPTH and never drops below 0.

**Errors**
- `wr_en` & !`wr_acc` sets `overflow`.
- `rd_en` & !`rd_acc` sets `underflow`.
- A rejected request has no other effect: memory, pointers and count are unchanged.
- Both flags stay set until `clear` or reset.

**Flush**
- `clear` has priority over `wr_en`/`rd_en` in the same cycle.
- It zeroes pointers, count, `overflow`, `underflow` and `rd_valid`.
- `buf_out` and memory contents are retained.

**Status flags**
- All status flags are registered and updated on the same edge as `fifo_counter`.
- They are always consistent with its post-edge value.

## Timing
**Reset** (asynchronous, takes effect immediately on `rst`=0)
- Pointers = 0, `fifo_counter` = 0, `buf_out` = 0.
- `buf_empty` = 1, `almost_empty` = 1 (AE_THRESH >= 0).
- `buf_full` = 0, `almost_full` = 0.
- `rd_valid` = 0, `overflow` = 0, `underflow` = 0.
- Deassertion is sampled as a synchronous release. The first accepted operation occurs on the first rising edge with `rst`=1.

**Write**: data is stored at edge N. It is poppable from the cycle after N.

**Read**: an accepted pop at edge N loads `mem[rd_ptr]` into `buf_out` at edge N.
- `rd_valid` = 1 during cycle N..N+1.
- `buf_out` holds its value until the next accepted pop.

**Mid-operation reset**: asserting reset mid-operation aborts any in-flight request with no partial update.

## Test plan
Parameters for all scenarios: DATA_WIDTH=8, ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=2.

1. **Reset and basic order.** Assert reset, release, push 1, 2, 3, then pop three times.
   - `buf_out` is 1, 2, 3 on successive pops, with `rd_valid` pulsing each time.
   - Count goes 0→3→0 and `buf_empty`=1 at the end.
2. **Fill, flags and overflow.** Push 10, 20, …, 90 (nine pushes).
   - `almost_full` rises when count reaches 6.
   - `buf_full` rises at 8.
   - The ninth push is rejected, `overflow`=1 and count stays 8.
   - Eight pops return 10..80.
3. **Simultaneous on full.** With the FIFO full of 10..80, assert push 100 and pop together.
   - `buf_out`=10 and count stays 8.
   - Eight further pops return 20..80, then 100.
4. **Simultaneous on empty.** From empty, assert push 5 and pop together.
   - Count=1, `underflow`=1, `rd_valid`=0.
   - The next pop returns 5.
5. **Wrap-around.** Repeat 20 times: push k, pop.
   - Each pop returns k, confirming pointer wrap.
   - Count alternates between 1 and 0, and no error flag sets.
6. **Clear and async reset.** With count=5, `overflow`=1 and `underflow`=1, assert `clear` together with `wr_en`.
   - Next cycle: count=0, `buf_empty`=1, both error flags cleared, and the write is not stored.
   - Push 7, then drop `rst` between edges: count reads 0 and `buf_out`=0 immediately, without waiting for an edge.
